// File: rtl/sound_player_if.sv
// sound_player_if: sound request in, speaker and status out.
// master drives codes and mute; slave is the player.
interface sound_player_if;
  logic [1:0] code_sound;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] playing_code;

  modport master (
    output code_sound,
    output mute,
    input  speaker,
    input  busy,
    input  playing_code
  );

  modport slave (
    input  code_sound,
    input  mute,
    output speaker,
    output busy,
    output playing_code
  );
endinterface

// File: rtl/sound_player.sv
// sound_player: turns sound codes into timed square-wave notes.
// Define SOUND_QUEUE_EN for a one-deep pending slot instead of retrigger.
module sound_player #(
  parameter int HALF_PING = 13636,
  parameter int HALF_PONG = 6818,
  parameter int HALF_GO1  = 9091,
  parameter int HALF_GO2  = 4545,
  parameter int TONE_LEN  = 1200000,
  parameter int GAP_LEN   = 600000
) (
  input logic           clk,
  input logic           clr,
  sound_player_if.slave sp
);
  localparam logic [23:0] TONE_END = 24'(TONE_LEN - 1);
  localparam logic [23:0] GAP_END  = 24'(GAP_LEN - 1);
  localparam logic [15:0] PING_END = 16'(HALF_PING - 1);
  localparam logic [15:0] PONG_END = 16'(HALF_PONG - 1);
  localparam logic [15:0] GO1_END  = 16'(HALF_GO1 - 1);
  localparam logic [15:0] GO2_END  = 16'(HALF_GO2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    TONE1,
    GAP,
    TONE2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [1:0]  play_q, play_d;
  logic        busy_q, busy_d;
  logic        tone_q, tone_d;
  logic        spk_q, spk_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [23:0] dcnt_q, dcnt_d;

  logic        ev;
  logic        abort;
  logic        dur_end;
  logic        half_end;
  logic        done;
  logic        start;
  logic        go_idle;
  logic [1:0]  new_code;
  logic [15:0] half_lim;

`ifdef SOUND_QUEUE_EN
  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_c_q, pend_c_d;
`endif

  always_comb begin
    code_d  = sp.code_sound;
    ev      = (sp.code_sound != code_q)
            && (sp.code_sound != 2'b00);
    abort   = (sp.code_sound == 2'b00)
            && (code_q != 2'b00);

    unique case (1'b1)
      state_q == TONE2: half_lim = GO2_END;
      play_q == 2'b01:  half_lim = PONG_END;
      play_q == 2'b10:  half_lim = PING_END;
      default:          half_lim = GO1_END;
    endcase

    dur_end  = dcnt_q == ((state_q == GAP) ? GAP_END : TONE_END);
    half_end = hcnt_q == half_lim;
    // a sequence ends after TONE2, or after TONE1 for single notes
    done     = dur_end
             && ((state_q == TONE2)
             || ((state_q == TONE1) && (play_q != 2'b11)));

    state_d  = state_q;
    play_d   = play_q;
    tone_d   = tone_q;
    hcnt_d   = hcnt_q;
    dcnt_d   = dcnt_q;
    start    = 1'b0;
    go_idle  = 1'b0;
    new_code = sp.code_sound;

`ifdef SOUND_QUEUE_EN
    pend_v_d = pend_v_q;
    pend_c_d = pend_c_q;
    if (abort) begin
      go_idle  = 1'b1;
      pend_v_d = 1'b0;
      pend_c_d = 2'b00;
    end else if (ev && ((state_q == IDLE) || done)) begin
      start    = 1'b1;
      pend_v_d = 1'b0;
      pend_c_d = 2'b00;
    end else if (done && pend_v_q) begin
      start    = 1'b1;
      new_code = pend_c_q;
      pend_v_d = 1'b0;
      pend_c_d = 2'b00;
    end else if (done) begin
      go_idle = 1'b1;
    end else if (ev) begin
      pend_v_d = 1'b1;
      pend_c_d = sp.code_sound;
    end
`else
    if (abort) begin
      go_idle = 1'b1;
    end else if (ev) begin
      start = 1'b1;
    end else if (done) begin
      go_idle = 1'b1;
    end
`endif

    if (start) begin
      state_d = TONE1;
      play_d  = new_code;
      tone_d  = 1'b0;
      hcnt_d  = 16'd0;
      dcnt_d  = 24'd0;
    end else if (go_idle) begin
      state_d = IDLE;
      play_d  = 2'b00;
      tone_d  = 1'b0;
      hcnt_d  = 16'd0;
      dcnt_d  = 24'd0;
    end else begin
      unique case (state_q)
        TONE1, TONE2: begin
          if (dur_end) begin
            state_d = GAP;
            tone_d  = 1'b0;
            hcnt_d  = 16'd0;
            dcnt_d  = 24'd0;
          end else begin
            dcnt_d = dcnt_q + 24'd1;
            if (half_end) begin
              hcnt_d = 16'd0;
              tone_d = ~tone_q;
            end else begin
              hcnt_d = hcnt_q + 16'd1;
            end
          end
        end
        GAP: begin
          if (dur_end) begin
            state_d = TONE2;
            tone_d  = 1'b0;
            hcnt_d  = 16'd0;
            dcnt_d  = 24'd0;
          end else begin
            dcnt_d = dcnt_q + 24'd1;
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = state_d != IDLE;
    spk_d  = tone_d & ~sp.mute;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      // track the input so a code held through reset is not an event
      code_q  <= sp.code_sound;
      play_q  <= 2'b00;
      busy_q  <= 1'b0;
      tone_q  <= 1'b0;
      spk_q   <= 1'b0;
      hcnt_q  <= 16'd0;
      dcnt_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
      tone_q  <= tone_d;
      spk_q   <= spk_d;
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

`ifdef SOUND_QUEUE_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      pend_v_q <= 1'b0;
      pend_c_q <= 2'b00;
    end else begin
      pend_v_q <= pend_v_d;
      pend_c_q <= pend_c_d;
    end
  end
`endif

  assign sp.speaker      = spk_q;
  assign sp.busy         = busy_q;
  assign sp.playing_code = play_q;
endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: directed and random stimulus against a
// timestamp-based model of note sequences.
module tb_sound_player;
  localparam int HP = 4;
  localparam int HQ = 2;
  localparam int H1 = 3;
  localparam int H2 = 1;
  localparam int TL = 40;
  localparam int GL = 10;
`ifdef SOUND_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] code = 2'b10;
  logic       mute = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  sound_player_if sp ();
  assign sp.code_sound = code;
  assign sp.mute       = mute;

  sound_player #(
    .HALF_PING(HP),
    .HALF_PONG(HQ),
    .HALF_GO1 (H1),
    .HALF_GO2 (H2),
    .TONE_LEN (TL),
    .GAP_LEN  (GL)
  ) dut (
    .clk(clk),
    .clr(clr),
    .sp (sp)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  bit         m_act = 1'b0;
  int         m_start = 0;
  logic [1:0] m_code = 2'b00;
  bit         m_pv = 1'b0;
  logic [1:0] m_pc = 2'b00;
  logic [1:0] m_prev = 2'b00;
  logic       exp_spk;
  logic       exp_busy;
  logic [1:0] exp_play;

  function automatic int seq_len(logic [1:0] c);
    return (c == 2'b11) ? (2 * TL + GL) : TL;
  endfunction

  function automatic logic tone_at(logic [1:0] c, int t);
    int h;
    if (c == 2'b11) begin
      if (t < TL) return 1'((t / H1) % 2);
      if (t < TL + GL) return 1'b0;
      return 1'(((t - TL - GL) / H2) % 2);
    end
    h = (c == 2'b10) ? HP : HQ;
    return 1'((t / h) % 2);
  endfunction

  task automatic model_edge();
    bit ev, ab, fin;
    cyc++;
    if (clr) begin
      m_act = 1'b0;
      m_pv  = 1'b0;
    end else begin
      ev  = (code != m_prev) && (code != 2'b00);
      ab  = (code == 2'b00) && (m_prev != 2'b00);
      fin = m_act && ((cyc - m_start) == seq_len(m_code));
      if (ab) begin
        m_act = 1'b0;
        m_pv  = 1'b0;
      end else if (ev && (!m_act || !QUEUE || fin)) begin
        m_act   = 1'b1;
        m_start = cyc;
        m_code  = code;
        m_pv    = 1'b0;
      end else if (ev) begin
        m_pv = 1'b1;
        m_pc = code;
      end else if (fin && m_pv) begin
        m_start = cyc;
        m_code  = m_pc;
        m_pv    = 1'b0;
      end else if (fin) begin
        m_act = 1'b0;
      end
    end
    m_prev = code;
    if (m_act) begin
      exp_busy = 1'b1;
      exp_play = m_code;
      exp_spk  = tone_at(m_code, cyc - m_start) & ~mute;
    end else begin
      exp_busy = 1'b0;
      exp_play = 2'b00;
      exp_spk  = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    n_chk++;
    assert (sp.speaker === exp_spk) else begin
      n_fail++;
      $error("FAIL speaker cyc=%0d got=%b exp=%b",
             cyc, sp.speaker, exp_spk);
    end
    n_chk++;
    assert (sp.busy === exp_busy) else begin
      n_fail++;
      $error("FAIL busy cyc=%0d got=%b exp=%b",
             cyc, sp.busy, exp_busy);
    end
    n_chk++;
    assert (sp.playing_code === exp_play) else begin
      n_fail++;
      $error("FAIL playing_code cyc=%0d got=%b exp=%b",
             cyc, sp.playing_code, exp_play);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_busy(int n, output int nb);
    nb = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sp.busy === 1'b1) nb++;
    end
  endtask

  task automatic chk_len(string tag, int got, int want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  initial begin
    int nb;
    int r;
    if (HP < 1 || HQ < 1 || H1 < 1 || H2 < 1 || TL < 2) begin
      $display("FAIL params out of range");
      $fatal(1);
    end

    // reset held with a code present, then released
    clr  = 1'b1;
    code = 2'b10;
    run(2);
    clr = 1'b0;
    run(5);

    // ping, then hold, then 10->00->10 replay
    code = 2'b00;
    step();
    code = 2'b10;
    run_busy(45, nb);
    chk_len("ping_busy_len", nb, TL);
    run(10);
    code = 2'b00;
    run(2);
    code = 2'b10;
    run_busy(45, nb);
    chk_len("replay_busy_len", nb, TL);

    // go chirp
    code = 2'b00;
    step();
    code = 2'b11;
    run_busy(95, nb);
    chk_len("go_busy_len", nb, 2 * TL + GL);

    // mute window inside a ping
    code = 2'b00;
    step();
    code = 2'b10;
    step();
    for (int i = 1; i < 45; i++) begin
      mute = (i >= 10) && (i <= 25);
      step();
    end
    mute = 1'b0;

    // overlap: pong requested at cycle 20 of a ping
    code = 2'b00;
    step();
    code = 2'b10;
    run_busy(20, nb);
    r = nb;
    code = 2'b01;
    run_busy(80, nb);
    chk_len("overlap_busy_len", r + nb, QUEUE ? 2 * TL : 20 + TL);

    // abort at cycle 15
    code = 2'b00;
    step();
    code = 2'b10;
    run(15);
    code = 2'b00;
    step();
    chk_len("abort_busy", int'(sp.busy), 0);

    // reset pulse in the gap of a go
    code = 2'b11;
    run(45);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_len("clr_gap_busy", int'(sp.busy), 0);
    run(5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) code = 2'($urandom_range(0, 3));
      if (r == 50) mute = ~mute;
      clr = (r == 77);
      step();
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
